pipeline_memp_dispatch: RTL and testbench

PIPELINE_MEMP_DISPATCH -- requirements
Module: pipeline_memp_dispatch

---
 rtl/pipeline_memp_dispatch.sv | 139 +++++++++++++
 tb/tb_pipeline_memp_dispatch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_memp_dispatch.sv
// rtl/pipeline_memp_dispatch.sv - EXA->MEMP stage register with address-decoded channel request dispatch
// Optional alignment fault checking is enabled by defining MEMP_MISALIGN_CHECK_EN.
module pipeline_memp_dispatch #(
   parameter int XLEN   = 64,
   parameter int NUM_CH = 2,
   parameter logic [NUM_CH*XLEN-1:0] CH_BASE = {64'h8000_0000, 64'h0},
   parameter logic [NUM_CH*XLEN-1:0] CH_MASK = {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000}
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic              valid_EXA,
   input  logic [XLEN-1:0]   pc_EXA,
   input  logic              rf_wr_en_EXA,
   input  logic [1:0]        rf_wr_sel_EXA,
   input  logic [XLEN-1:0]   alu_result_EXA,
   input  logic [2:0]        dm_rd_ctrl_EXA,
   input  logic [2:0]        dm_wr_ctrl_EXA,
   input  logic [1:0]        acc_size_EXA,
   input  logic [XLEN-1:0]   reg_data2_EXA,
   input  logic [4:0]        rd_EXA,
   output logic [NUM_CH-1:0] ch_req_valid,
   input  logic [NUM_CH-1:0] ch_req_ready,
   output logic [XLEN-1:0]   ch_addr,
   output logic [XLEN-1:0]   ch_wdata,
   output logic [2:0]        ch_rd_ctrl,
   output logic [2:0]        ch_wr_ctrl,
   output logic              stall_req,
   output logic              valid_MEMP,
   output logic [XLEN-1:0]   pc_MEMP,
   output logic              rf_wr_en_MEMP,
   output logic [1:0]        rf_wr_sel_MEMP,
   output logic [XLEN-1:0]   alu_result_MEMP,
   output logic [4:0]        rd_MEMP,
   output logic [NUM_CH-1:0] ch_sel_MEMP,
   output logic              fault_MEMP
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;
   state_t state;

   logic              mem_op;
   logic              misalign;
   logic [NUM_CH-1:0] hit_oh;
   logic              hit_any;
   logic              issue;
   logic              ready_hit;

   assign mem_op = valid_EXA & ((dm_rd_ctrl_EXA != 3'd0) | (dm_wr_ctrl_EXA != 3'd0));

   // Priority decode: the first matching channel (lowest index) claims the access.
   always_comb begin
      hit_oh  = '0;
      hit_any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!hit_any &&
             ((alu_result_EXA & CH_MASK[i*XLEN +: XLEN]) == CH_BASE[i*XLEN +: XLEN])) begin
            hit_oh[i] = 1'b1;
            hit_any   = 1'b1;
         end
      end
   end

`ifdef MEMP_MISALIGN_CHECK_EN
   always_comb begin
      misalign = 1'b0;
      case (acc_size_EXA)
         2'd1:    misalign = alu_result_EXA[0];
         2'd2:    misalign = |alu_result_EXA[1:0];
         2'd3:    misalign = |alu_result_EXA[2:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   logic unused_acc_size;
   assign unused_acc_size = ^acc_size_EXA;
   assign misalign        = 1'b0;
`endif

   assign issue     = mem_op & hit_any & ~misalign;
   assign ready_hit = |(ch_req_valid & ch_req_ready);
   assign stall_req = (state == S_WAIT) & ~ready_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         ch_req_valid    <= '0;
         ch_addr         <= '0;
         ch_wdata        <= '0;
         ch_rd_ctrl      <= '0;
         ch_wr_ctrl      <= '0;
         valid_MEMP      <= 1'b0;
         pc_MEMP         <= '0;
         rf_wr_en_MEMP   <= 1'b0;
         rf_wr_sel_MEMP  <= '0;
         alu_result_MEMP <= '0;
         rd_MEMP         <= '0;
         ch_sel_MEMP     <= '0;
         fault_MEMP      <= 1'b0;
      end else if (state == S_WAIT && !ready_hit) begin
         // Request is never withdrawn; a flush only kills the instruction.
         if (flush)
            valid_MEMP <= 1'b0;
      end else if (!stall) begin
         // IDLE, or WAIT completing this cycle: take the next instruction back-to-back.
         valid_MEMP      <= valid_EXA & ~flush;
         pc_MEMP         <= pc_EXA;
         rf_wr_en_MEMP   <= rf_wr_en_EXA;
         rf_wr_sel_MEMP  <= rf_wr_sel_EXA;
         alu_result_MEMP <= alu_result_EXA;
         rd_MEMP         <= rd_EXA;
         fault_MEMP      <= mem_op & (~hit_any | misalign);
         if (issue) begin
            state        <= S_WAIT;
            ch_req_valid <= hit_oh;
            ch_sel_MEMP  <= hit_oh;
            ch_addr      <= alu_result_EXA;
            ch_wdata     <= reg_data2_EXA;
            ch_rd_ctrl   <= dm_rd_ctrl_EXA;
            ch_wr_ctrl   <= dm_wr_ctrl_EXA;
         end else begin
            state        <= S_IDLE;
            ch_req_valid <= '0;
            ch_sel_MEMP  <= '0;
            ch_addr      <= '0;
            ch_wdata     <= '0;
            ch_rd_ctrl   <= '0;
            ch_wr_ctrl   <= '0;
         end
      end else if (state == S_WAIT) begin
         state        <= S_IDLE;
         ch_req_valid <= '0;
         if (flush)
            valid_MEMP <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_memp_dispatch.sv
// tb/tb_pipeline_memp_dispatch.sv - directed self-checking bench for pipeline_memp_dispatch
module tb_pipeline_memp_dispatch;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush, valid_EXA, rf_wr_en_EXA;
   logic [63:0] pc_EXA, alu_result_EXA, reg_data2_EXA;
   logic [1:0]  rf_wr_sel_EXA, acc_size_EXA;
   logic [2:0]  dm_rd_ctrl_EXA, dm_wr_ctrl_EXA;
   logic [4:0]  rd_EXA;
   logic [1:0]  ch_req_ready;

   logic [1:0]  ch_req_valid, ch_sel_MEMP;
   logic [63:0] ch_addr, ch_wdata, pc_MEMP, alu_result_MEMP;
   logic [2:0]  ch_rd_ctrl, ch_wr_ctrl;
   logic        stall_req, valid_MEMP, rf_wr_en_MEMP, fault_MEMP;
   logic [1:0]  rf_wr_sel_MEMP;
   logic [4:0]  rd_MEMP;

   logic [1:0]  m_ch_req_valid, m_ch_sel_MEMP;
   logic [63:0] m_ch_addr, m_ch_wdata, m_pc_MEMP, m_alu_result_MEMP;
   logic [2:0]  m_ch_rd_ctrl, m_ch_wr_ctrl;
   logic        m_stall_req, m_valid_MEMP, m_rf_wr_en_MEMP, m_fault_MEMP;
   logic [1:0]  m_rf_wr_sel_MEMP;
   logic [4:0]  m_rd_MEMP;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pipeline_memp_dispatch dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_EXA(valid_EXA),
      .pc_EXA(pc_EXA), .rf_wr_en_EXA(rf_wr_en_EXA), .rf_wr_sel_EXA(rf_wr_sel_EXA),
      .alu_result_EXA(alu_result_EXA), .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA),
      .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA), .acc_size_EXA(acc_size_EXA),
      .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA),
      .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_rd_ctrl(ch_rd_ctrl), .ch_wr_ctrl(ch_wr_ctrl),
      .stall_req(stall_req), .valid_MEMP(valid_MEMP), .pc_MEMP(pc_MEMP),
      .rf_wr_en_MEMP(rf_wr_en_MEMP), .rf_wr_sel_MEMP(rf_wr_sel_MEMP),
      .alu_result_MEMP(alu_result_MEMP), .rd_MEMP(rd_MEMP),
      .ch_sel_MEMP(ch_sel_MEMP), .fault_MEMP(fault_MEMP)
   );

   // All-ones compare mask: only exact base addresses hit.
   pipeline_memp_dispatch #(
      .CH_MASK({2{64'hFFFF_FFFF_FFFF_FFFF}})
   ) dut_m (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_EXA(valid_EXA),
      .pc_EXA(pc_EXA), .rf_wr_en_EXA(rf_wr_en_EXA), .rf_wr_sel_EXA(rf_wr_sel_EXA),
      .alu_result_EXA(alu_result_EXA), .dm_rd_ctrl_EXA(dm_rd_ctrl_EXA),
      .dm_wr_ctrl_EXA(dm_wr_ctrl_EXA), .acc_size_EXA(acc_size_EXA),
      .reg_data2_EXA(reg_data2_EXA), .rd_EXA(rd_EXA),
      .ch_req_valid(m_ch_req_valid), .ch_req_ready(2'b11), .ch_addr(m_ch_addr),
      .ch_wdata(m_ch_wdata), .ch_rd_ctrl(m_ch_rd_ctrl), .ch_wr_ctrl(m_ch_wr_ctrl),
      .stall_req(m_stall_req), .valid_MEMP(m_valid_MEMP), .pc_MEMP(m_pc_MEMP),
      .rf_wr_en_MEMP(m_rf_wr_en_MEMP), .rf_wr_sel_MEMP(m_rf_wr_sel_MEMP),
      .alu_result_MEMP(m_alu_result_MEMP), .rd_MEMP(m_rd_MEMP),
      .ch_sel_MEMP(m_ch_sel_MEMP), .fault_MEMP(m_fault_MEMP)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic v, input logic [2:0] rdc, input logic [2:0] wrc,
                           input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] data, input logic [63:0] pc);
      valid_EXA      = v;
      dm_rd_ctrl_EXA = rdc;
      dm_wr_ctrl_EXA = wrc;
      acc_size_EXA   = size;
      alu_result_EXA = addr;
      reg_data2_EXA  = data;
      pc_EXA         = pc;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      rf_wr_en_EXA = 1'b1; rf_wr_sel_EXA = 2'd1; rd_EXA = 5'd5;
      ch_req_ready = 2'b00;
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h0);
      tick();
      tick();
      check("rst_req_valid", 64'(ch_req_valid), 64'h0);
      check("rst_valid_memp", 64'(valid_MEMP), 64'h0);
      check("rst_stall_req", 64'(stall_req), 64'h0);
      reset = 1'b1;

      // load to channel 1, accepted immediately
      ch_req_ready = 2'b11;
      drive_op(1'b1, 3'd1, 3'd0, 2'd2, 64'h8000_0010, 64'h0, 64'h1000);
      tick();
      check("ld_req_valid", 64'(ch_req_valid), 64'h2);
      check("ld_sel", 64'(ch_sel_MEMP), 64'h2);
      check("ld_addr", ch_addr, 64'h8000_0010);
      check("ld_pc", pc_MEMP, 64'h1000);
      check("ld_rd", 64'(rd_MEMP), 64'h5);
      check("ld_valid_memp", 64'(valid_MEMP), 64'h1);
      check("ld_stall_req", 64'(stall_req), 64'h0);
      check("ld_fault", 64'(fault_MEMP), 64'h0);
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h1004);
      tick();
      check("ld_req_drop", 64'(ch_req_valid), 64'h0);
      check("nonmem_addr_zero", ch_addr, 64'h0);
      check("nonmem_sel_zero", 64'(ch_sel_MEMP), 64'h0);

      // store to channel 0 with ready low for three cycles
      ch_req_ready = 2'b00;
      drive_op(1'b1, 3'd0, 3'd2, 2'd3, 64'h100, 64'hDEAD, 64'h2000);
      tick();
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h2004);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("st_req_valid_%0d", i), 64'(ch_req_valid), 64'h1);
         check($sformatf("st_wdata_%0d", i), ch_wdata, 64'hDEAD);
         check($sformatf("st_stall_req_%0d", i), 64'(stall_req), 64'h1);
         tick();
      end
      ch_req_ready = 2'b01;
      #1;
      check("st_req_valid_3", 64'(ch_req_valid), 64'h1);
      check("st_wdata_3", ch_wdata, 64'hDEAD);
      check("st_wr_ctrl_3", 64'(ch_wr_ctrl), 64'h2);
      check("st_stall_req_3", 64'(stall_req), 64'h0);
      tick();
      check("st_done_valid", 64'(ch_req_valid), 64'h0);
      check("st_done_wdata", ch_wdata, 64'h0);

      // unmapped access on both decoders
      ch_req_ready = 2'b00;
      drive_op(1'b1, 3'd1, 3'd0, 2'd3, 64'h1_0000_0000, 64'h0, 64'h3000);
      tick();
      check("um_fault", 64'(fault_MEMP), 64'h1);
      check("um_req_valid", 64'(ch_req_valid), 64'h0);
      check("um_sel", 64'(ch_sel_MEMP), 64'h0);
      check("um_stall_req", 64'(stall_req), 64'h0);
      check("um_m_fault", 64'(m_fault_MEMP), 64'h1);
      check("um_m_req_valid", 64'(m_ch_req_valid), 64'h0);
      tick();
      check("um_stall_req_2", 64'(stall_req), 64'h0);
      check("um_m_stall_req", 64'(m_stall_req), 64'h0);

      // misaligned word load
      ch_req_ready = 2'b11;
      drive_op(1'b1, 3'd1, 3'd0, 2'd2, 64'h8000_0002, 64'h0, 64'h4000);
      tick();
`ifdef MEMP_MISALIGN_CHECK_EN
      check("mis_fault", 64'(fault_MEMP), 64'h1);
      check("mis_req_valid", 64'(ch_req_valid), 64'h0);
`else
      check("mis_fault", 64'(fault_MEMP), 64'h0);
      check("mis_req_valid", 64'(ch_req_valid), 64'h2);
`endif

      // back-to-back issue with zero-wait acceptance
      drive_op(1'b1, 3'd1, 3'd0, 2'd2, 64'h8000_0020, 64'h0, 64'h5000);
      tick();
      check("b2b_first_valid", 64'(ch_req_valid), 64'h2);
      check("b2b_first_addr", ch_addr, 64'h8000_0020);
      check("b2b_stall_req", 64'(stall_req), 64'h0);
      drive_op(1'b1, 3'd0, 3'd1, 2'd2, 64'h200, 64'h55, 64'h5004);
      tick();
      check("b2b_second_valid", 64'(ch_req_valid), 64'h1);
      check("b2b_second_addr", ch_addr, 64'h200);
      check("b2b_second_pc", pc_MEMP, 64'h5004);

      // stall in IDLE freezes the stage
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h600);
      tick();
      check("stl_pc_before", pc_MEMP, 64'h600);
      stall = 1'b1;
      drive_op(1'b1, 3'd1, 3'd0, 2'd2, 64'h8000_0010, 64'h0, 64'h700);
      tick();
      check("stl_pc_frozen", pc_MEMP, 64'h600);
      check("stl_no_req", 64'(ch_req_valid), 64'h0);
      stall = 1'b0;

      // flush while waiting still completes the handshake
      ch_req_ready = 2'b00;
      drive_op(1'b1, 3'd1, 3'd0, 2'd2, 64'h8000_0010, 64'h0, 64'h800);
      tick();
      check("fl_valid_memp_pre", 64'(valid_MEMP), 64'h1);
      flush = 1'b1;
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'h804);
      tick();
      flush = 1'b0;
      check("fl_valid_memp", 64'(valid_MEMP), 64'h0);
      check("fl_req_held", 64'(ch_req_valid), 64'h2);
      check("fl_stall_req", 64'(stall_req), 64'h1);
      ch_req_ready = 2'b10;
      #1;
      check("fl_stall_req_rdy", 64'(stall_req), 64'h0);
      tick();
      check("fl_req_done", 64'(ch_req_valid), 64'h0);

      // reset asserted mid-WAIT
      ch_req_ready = 2'b00;
      drive_op(1'b1, 3'd0, 3'd1, 2'd3, 64'h8000_0040, 64'h1234, 64'h900);
      tick();
      check("rw_in_wait", 64'(stall_req), 64'h1);
      reset = 1'b0;
      #1;
      check("rw_req_valid", 64'(ch_req_valid), 64'h0);
      check("rw_stall_req", 64'(stall_req), 64'h0);
      check("rw_valid_memp", 64'(valid_MEMP), 64'h0);
      check("rw_addr", ch_addr, 64'h0);
      check("rw_wdata", ch_wdata, 64'h0);
      check("rw_pc", pc_MEMP, 64'h0);
      tick();
      reset = 1'b1;
      drive_op(1'b0, 3'd0, 3'd0, 2'd0, 64'h0, 64'h0, 64'hA00);
      tick();
      check("rw_idle_stall", 64'(stall_req), 64'h0);
      check("rw_resume_pc", pc_MEMP, 64'hA00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
